// File: rtl/mmu_fetch_responder.sv
// Purpose: memory-side responder for CU fetch/access requests, owning a word-organised SRAM array.
// Latency: LATENCY edges from accept to the one-cycle mem_valid pulse; one idle cycle before the next accept.
// Backpressure: mem_busy is high while a request is in flight; memfetch_start is ignored (not queued) then.
module mmu_fetch_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        soc_clk,
    input  logic        MMU_reset_n,
    input  logic        memfetch_start,
    input  logic [31:0] addr,
    input  logic [3:0]  bits_to_access,
    input  logic        read_or_write,
    input  logic [31:0] wdata,
    output logic        mem_busy,
    output logic        mem_valid,
    output logic        mem_err,
    output logic [31:0] mem_data
);

    localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);
    localparam logic [32:0] DEPTH_WORDS = 33'(1) << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       do_access;

    // Latched request; only meaningful while the FSM is out of IDLE.
    logic [31:0] req_addr;
    logic [3:0]  req_lanes;
    logic        req_write;
    logic [31:0] req_wdata;

    logic [31:0] offset;
    logic [31:0] word_off;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic        req_err;
    logic [31:0] lane_mask;
    logic [31:0] rd_word;

    logic [31:0] mem [2**DEPTH_LOG2];

    // State and countdown register; reset discards any in-flight request.
    always_ff @(posedge soc_clk) begin
        if (!MMU_reset_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic, countdown and the status outputs decoded from the state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        do_access = 1'b0;
        mem_busy  = (state != S_IDLE);
        mem_valid = (state == S_RESP);
        case (state)
            S_IDLE: begin
                if (memfetch_start) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    do_access = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the request fields at accept so later input changes cannot disturb it.
    always_ff @(posedge soc_clk) begin
        if (accept) begin
            req_addr  <= addr;
            req_lanes <= bits_to_access;
            req_write <= read_or_write;
            req_wdata <= wdata;
        end
    end

    // Address decode and error check on the latched request; the subtraction may wrap,
    // but the explicit below-base compare keeps a wrapped value from ever being used.
    always_comb begin
        offset   = req_addr - BASE_ADDR;
        word_off = offset >> 2;
        req_idx  = word_off[DEPTH_LOG2-1:0];
        req_err  = (req_addr[1:0] != 2'b00)
                 || (req_addr < BASE_ADDR)
                 || ({1'b0, word_off} >= DEPTH_WORDS)
                 || (req_lanes == 4'b0000);
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{req_lanes[i]}};
        end
        rd_word = mem[req_idx];
    end

    // Array write on the WAIT->RESP edge; a same-edge reset cancels it. Contents are never reset.
    always_ff @(posedge soc_clk) begin
        if (MMU_reset_n && do_access && req_write && !req_err) begin
            mem[req_idx] <= (rd_word & ~lane_mask) | (req_wdata & lane_mask);
        end
    end

    // Response registers: updated only when an access completes, held otherwise.
    always_ff @(posedge soc_clk) begin
        if (!MMU_reset_n) begin
            mem_err  <= 1'b0;
            mem_data <= 32'h0;
        end else if (do_access) begin
            mem_err  <= req_err;
            mem_data <= (req_err || req_write) ? 32'h0 : (rd_word & lane_mask);
        end
    end

endmodule

// File: tb/tb_mmu_fetch_responder.sv
// Directed bench: a vector table on the LATENCY=2 build, plus hand-written sequences for
// back-to-back requests, reset mid-operation, and the LATENCY=1 / LATENCY=15 builds.
module tb_mmu_fetch_responder;

    logic        clk;
    logic        rst_n;
    logic        start2, start1, start15;
    logic [31:0] addr;
    logic [3:0]  lanes;
    logic        rw;
    logic [31:0] wdata;

    logic        busy2, valid2, err2;
    logic [31:0] data2;
    logic        busy1, valid1, err1;
    logic [31:0] data1;
    logic        busy15, valid15, err15;
    logic [31:0] data15;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mmu_fetch_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .LATENCY(2)) u_dut (
        .soc_clk(clk), .MMU_reset_n(rst_n), .memfetch_start(start2), .addr(addr),
        .bits_to_access(lanes), .read_or_write(rw), .wdata(wdata),
        .mem_busy(busy2), .mem_valid(valid2), .mem_err(err2), .mem_data(data2));

    mmu_fetch_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
        .soc_clk(clk), .MMU_reset_n(rst_n), .memfetch_start(start1), .addr(addr),
        .bits_to_access(lanes), .read_or_write(rw), .wdata(wdata),
        .mem_busy(busy1), .mem_valid(valid1), .mem_err(err1), .mem_data(data1));

    mmu_fetch_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0), .LATENCY(15)) u_l15 (
        .soc_clk(clk), .MMU_reset_n(rst_n), .memfetch_start(start15), .addr(addr),
        .bits_to_access(lanes), .read_or_write(rw), .wdata(wdata),
        .mem_busy(busy15), .mem_valid(valid15), .mem_err(err15), .mem_data(data15));

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  lanes;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy2 : (sel == 1) ? busy1 : busy15;
    endfunction
    function automatic logic get_valid(input int sel);
        return (sel == 0) ? valid2 : (sel == 1) ? valid1 : valid15;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? err2 : (sel == 1) ? err1 : err15;
    endfunction
    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? data2 : (sel == 1) ? data1 : data15;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start2 = v;
        else if (sel == 1) start1 = v;
        else start15 = v;
    endtask

    // One request on the selected instance; entered and left at posedge+1 with the DUT idle.
    task automatic do_req(input int sel, input string name, input logic r_w, input logic [31:0] a,
                          input logic [3:0] ln, input logic [31:0] wd, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err);
        int n;
        logic [31:0] got_data;
        logic        got_err;
        rw    = r_w;
        addr  = a;
        lanes = ln;
        wdata = wd;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        chk({name, " busy_after_accept"}, 32'(get_busy(sel)), 32'd1);
        n = 0;
        while (!get_valid(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!get_valid(sel)) begin
            chk({name, " timeout_valid"}, 32'(get_valid(sel)), 32'd1);
            return;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        got_data = get_data(sel);
        got_err  = get_err(sel);
        chk({name, " data"}, got_data, exp_data);
        chk({name, " err"}, 32'(got_err), 32'(exp_err));
        @(posedge clk); #1;
        chk({name, " valid_one_cycle"}, 32'(get_valid(sel)), 32'd0);
        chk({name, " busy_drop"}, 32'(get_busy(sel)), 32'd0);
        chk({name, " data_held"}, get_data(sel), exp_data);
        chk({name, " err_held"}, 32'(get_err(sel)), 32'(exp_err));
    endtask

    initial begin
        int nvalid;
        rst_n   = 1'b0;
        start2  = 1'b0;
        start1  = 1'b0;
        start15 = 1'b0;
        addr    = 32'h0;
        lanes   = 4'h0;
        rw      = 1'b0;
        wdata   = 32'h0;

        //                rw    addr           lanes  wdata          exp_data       err
        vecs.push_back('{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 4'h5, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDE22BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'h3, 32'h0,        32'h0000BE44, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0012, 4'hF, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_1000, 4'hF, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0012, 4'hF, 32'h55555555, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_1000, 4'hF, 32'h77777777, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'hF, 32'h0,        32'hDE22BE44, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 4'hF, 32'h01020304, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 4'hF, 32'h0,        32'h01020304, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 4'hF, 32'h0,        32'h0,        1'b0});

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy2), 32'd0);
        chk("reset valid", 32'(valid2), 32'd0);
        chk("reset err", 32'(err2), 32'd0);
        chk("reset data", data2, 32'h0);
        chk("reset l15 busy", 32'(busy15), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word 0 is written once so the final table read of address 0 has a known value.
        do_req(0, "init_w0", 1'b1, 32'h0, 4'hF, 32'h0, 2, 32'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(0, $sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].lanes,
                   vecs[i].wdata, 2, vecs[i].exp_data, vecs[i].exp_err);
        end

        // memfetch_start held high: accepts every 4 edges, one idle cycle between requests.
        rw    = 1'b0;
        addr  = 32'h10;
        lanes = 4'hF;
        start2 = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk($sformatf("stream busy e%0d", i), 32'(busy2), ((i % 4) == 3) ? 32'd0 : 32'd1);
            chk($sformatf("stream valid e%0d", i), 32'(valid2), ((i % 4) == 2) ? 32'd1 : 32'd0);
            if (valid2) begin
                nvalid++;
                chk($sformatf("stream data e%0d", i), data2, 32'hDE22BE44);
            end
        end
        start2 = 1'b0;
        chk("stream valid count", 32'(nvalid), 32'd3);

        // Reset during WAIT (edge k+1) and on the WAIT->RESP edge (k+2) both drop the write.
        do_req(0, "rst_pre_w", 1'b1, 32'h20, 4'hF, 32'h12345678, 2, 32'h0, 1'b0);
        do_req(0, "rst_pre_r", 1'b0, 32'h20, 4'hF, 32'h0, 2, 32'h12345678, 1'b0);
        for (int d = 1; d <= 2; d++) begin
            rw    = 1'b1;
            addr  = 32'h20;
            lanes = 4'hF;
            wdata = 32'hCAFEF00D;
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            for (int j = 1; j < d; j++) begin
                @(posedge clk); #1;
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            chk($sformatf("rst_d%0d busy", d), 32'(busy2), 32'd0);
            chk($sformatf("rst_d%0d valid", d), 32'(valid2), 32'd0);
            chk($sformatf("rst_d%0d err", d), 32'(err2), 32'd0);
            chk($sformatf("rst_d%0d data", d), data2, 32'h0);
            nvalid = 0;
            for (int j = 0; j < 6; j++) begin
                @(posedge clk); #1;
                if (valid2) nvalid++;
            end
            chk($sformatf("rst_d%0d no_valid", d), 32'(nvalid), 32'd0);
            do_req(0, $sformatf("rst_d%0d read_old", d), 1'b0, 32'h20, 4'hF, 32'h0, 2,
                   32'h12345678, 1'b0);
        end

        // Latency extremes.
        do_req(1, "l1_w", 1'b1, 32'h40, 4'hF, 32'hA5A5A5A5, 1, 32'h0, 1'b0);
        do_req(1, "l1_r", 1'b0, 32'h40, 4'hF, 32'h0, 1, 32'hA5A5A5A5, 1'b0);
        do_req(1, "l1_r_lane", 1'b0, 32'h40, 4'h8, 32'h0, 1, 32'hA5000000, 1'b0);
        do_req(2, "l15_w", 1'b1, 32'h40, 4'hF, 32'h5A5AC3C3, 15, 32'h0, 1'b0);
        do_req(2, "l15_r", 1'b0, 32'h40, 4'hF, 32'h0, 15, 32'h5A5AC3C3, 1'b0);
        do_req(2, "l15_err", 1'b0, 32'h41, 4'hF, 32'h0, 15, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
